// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, field-width helpers and request-type constants for data_cache
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WB_REQ,
        ALLOC_REQ,
        ALLOC_WAIT
    } cache_state_e;

    localparam logic MEM_RW_LOAD  = 1'b0;
    localparam logic MEM_RW_STORE = 1'b1;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int line_bytes, input int num_sets);
        return 32 - off_width(line_bytes) - idx_width(num_sets);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - tag/valid/dirty/data storage with async read and sync fill/store
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 16,
    localparam int IDX_W     = idx_width(NUM_SETS),
    localparam int TAG_W     = tag_width(LINE_BYTES, NUM_SETS),
    localparam int WSEL_W    = off_width(LINE_BYTES) - 2,
    localparam int LINE_W    = LINE_BYTES * 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_index,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              fill_en,
    input  logic [IDX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              store_en,
    input  logic [IDX_W-1:0]  store_index,
    input  logic [WSEL_W-1:0] store_word,
    input  logic [31:0]       store_data
);

    logic [NUM_SETS-1:0] valid_bits;
    logic [NUM_SETS-1:0] dirty_bits;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [LINE_W-1:0]   data_mem [NUM_SETS];

    assign rd_valid = valid_bits[rd_index];
    assign rd_dirty = dirty_bits[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

    // Only the state bits are cleared on reset; tag and data contents survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill_en) begin
            valid_bits[fill_index] <= 1'b1;
            dirty_bits[fill_index] <= 1'b0;
        end else if (store_en) begin
            dirty_bits[store_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= fill_line;
        end else if (!reset && store_en) begin
            data_mem[store_index][32*store_word +: 32] <= store_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache with line-granular backing port
module data_cache
    import cache_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_rw,
    input  logic [31:0]             din,
    output logic                    is_ready,
    output logic                    is_output_valid,
    output logic [31:0]             dout,
    output logic                    is_hit,
    output logic                    mem_req_valid,
    output logic                    mem_req_write,
    output logic [31:0]             mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_req_data,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int OFF    = off_width(LINE_BYTES);
    localparam int IDX    = idx_width(NUM_SETS);
    localparam int TAG_W  = tag_width(LINE_BYTES, NUM_SETS);
    localparam int WSEL_W = OFF - 2;
    localparam int LINE_W = LINE_BYTES * 8;

    cache_state_e      state;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX-1:0]    req_index;
    logic [WSEL_W-1:0] req_word;
    logic              req_rw;
    logic [31:0]       req_din;
    logic              first_cmp;
    logic [31:0]       dout_q;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              hit;
    logic [31:0]       sel_word;
    logic              resp_fire;
    logic              fill_en;
    logic              store_en;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^addr[1:0];

    cache_line_array #(
        .LINE_BYTES (LINE_BYTES),
        .NUM_SETS   (NUM_SETS)
    ) u_lines (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (req_index),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .fill_en     (fill_en),
        .fill_index  (req_index),
        .fill_tag    (req_tag),
        .fill_line   (mem_resp_data),
        .store_en    (store_en),
        .store_index (req_index),
        .store_word  (req_word),
        .store_data  (req_din)
    );

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign sel_word  = rd_line[32*req_word +: 32];
    assign resp_fire = !reset && (state == COMPARE) && hit;
    assign store_en  = resp_fire && (req_rw == MEM_RW_STORE);
    assign fill_en   = !reset && (state == ALLOC_WAIT) && mem_resp_valid;

    // The response is combinational in the compare cycle so a hit costs one cycle.
    assign is_ready        = !reset && (state == IDLE);
    assign is_output_valid = resp_fire;

    always_comb begin
        dout = dout_q;
        if (reset)
            dout = '0;
        else if (resp_fire && req_rw == MEM_RW_LOAD)
            dout = sel_word;
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        if (!reset && state == WB_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_req_addr  = {rd_tag, req_index, {OFF{1'b0}}};
            mem_req_data  = rd_line;
        end else if (!reset && state == ALLOC_REQ) begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_tag, req_index, {OFF{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            req_rw     <= MEM_RW_LOAD;
            req_din    <= '0;
            first_cmp  <= 1'b0;
            dout_q     <= '0;
            is_hit     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_input_valid) begin
                        req_tag   <= addr[31:OFF+IDX];
                        req_index <= addr[OFF+IDX-1:OFF];
                        req_word  <= addr[OFF-1:2];
                        req_rw    <= mem_rw;
                        req_din   <= din;
                        first_cmp <= 1'b1;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    // Status is captured only on the first compare, not the replay after a fill.
                    if (first_cmp) begin
                        is_hit    <= hit;
                        first_cmp <= 1'b0;
                        if (hit)
                            hit_count <= hit_count + 32'd1;
                        else
                            miss_count <= miss_count + 32'd1;
                    end
                    if (hit) begin
                        if (req_rw == MEM_RW_LOAD)
                            dout_q <= sel_word;
                        state <= IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        state <= WB_REQ;
                    end else begin
                        state <= ALLOC_REQ;
                    end
                end
                WB_REQ: begin
                    if (mem_req_ready)
                        state <= ALLOC_REQ;
                end
                ALLOC_REQ: begin
                    if (mem_req_ready)
                        state <= ALLOC_WAIT;
                end
                ALLOC_WAIT: begin
                    if (mem_resp_valid)
                        state <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache with a behavioural memory and cache model
module tb_data_cache;

    localparam int LBITS = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic             is_input_valid;
    logic [31:0]      addr;
    logic             mem_rw;
    logic [31:0]      din;
    logic             is_ready;
    logic             is_output_valid;
    logic [31:0]      dout;
    logic             is_hit;
    logic             mem_req_valid;
    logic             mem_req_write;
    logic [31:0]      mem_req_addr;
    logic [LBITS-1:0] mem_req_data;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [LBITS-1:0] mem_resp_data;
    logic [31:0]      hit_count;
    logic [31:0]      miss_count;

    always #5 clk = ~clk;

    data_cache #(.LINE_BYTES(16), .NUM_SETS(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (is_input_valid),
        .addr            (addr),
        .mem_rw          (mem_rw),
        .din             (din),
        .is_ready        (is_ready),
        .is_output_valid (is_output_valid),
        .dout            (dout),
        .is_hit          (is_hit),
        .mem_req_valid   (mem_req_valid),
        .mem_req_write   (mem_req_write),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]      bk      [int unsigned];
    logic [31:0]      ref_mem [int unsigned];
    logic [31:0]      wb_addr_q[$];
    logic [LBITS-1:0] wb_data_q[$];
    logic [31:0]      fetch_addr_q[$];

    int wb_stall = 0, fetch_stall = 0, resp_n = 3;
    bit hold_resp = 0, inject_resp = 0;
    int stable_err = 0, idle_err = 0;

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] bk_word(input int unsigned wa);
        if (bk.exists(wa)) return bk[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    // Backing memory: acts a little after each rising edge, well clear of the sampling edge.
    initial begin
        int stall_left = 0, resp_cnt = 0;
        bit req_active = 0;
        logic [31:0] snap_addr;
        logic [LBITS-1:0] snap_data, pending_line;
        logic snap_write;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        forever begin
            @(posedge clk); #2;
            mem_req_ready = 0; mem_resp_valid = 0;
            if (reset) begin
                req_active = 0; resp_cnt = 0;
            end else begin
                if (inject_resp) begin
                    inject_resp = 0; mem_resp_valid = 1; mem_resp_data = {4{32'hBAD0_BAD0}};
                end
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        mem_resp_valid = 1; mem_resp_data = pending_line;
                    end
                end
                if (mem_req_valid) begin
                    if (!req_active) begin
                        req_active = 1;
                        stall_left = mem_req_write ? wb_stall : fetch_stall;
                        snap_addr = mem_req_addr; snap_data = mem_req_data; snap_write = mem_req_write;
                    end else if (mem_req_addr !== snap_addr || mem_req_data !== snap_data || mem_req_write !== snap_write) begin
                        stable_err++;
                    end
                    if (stall_left == 0) begin
                        mem_req_ready = 1; req_active = 0;
                        if (mem_req_write) begin
                            wb_addr_q.push_back(mem_req_addr);
                            wb_data_q.push_back(mem_req_data);
                            for (int w = 0; w < 4; w++) bk[(mem_req_addr >> 2) + w] = mem_req_data[w*32 +: 32];
                        end else begin
                            fetch_addr_q.push_back(mem_req_addr);
                            for (int w = 0; w < 4; w++) pending_line[w*32 +: 32] = bk_word((mem_req_addr >> 2) + w);
                            if (!hold_resp) resp_cnt = resp_n + 1;
                        end
                    end else begin
                        stall_left--;
                    end
                end else if (mem_req_write !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_data !== '0) begin
                    idle_err++;
                end
            end
        end
    end

    // Drives one request and waits for its response; lat counts cycles from acceptance.
    task automatic do_request(input logic [31:0] a, input logic rw, input logic [31:0] d,
                              output logic [31:0] rdata, output int lat, output int ready_seen);
        int n = 0;
        ready_seen = 0; lat = 0; rdata = 'x;
        @(negedge clk);
        while (!is_ready && n < 50) begin @(negedge clk); n++; end
        if (!is_ready) begin
            errors++; checks++;
            $display("FAIL req_accept_timeout: is_ready got %b required 1", is_ready);
            return;
        end
        is_input_valid = 1; addr = a; mem_rw = rw; din = d;
        @(negedge clk);
        is_input_valid = 0; lat = 1;
        while (!is_output_valid && lat < 300) begin
            if (is_ready) ready_seen++;
            @(negedge clk); lat++;
        end
        if (!is_output_valid) begin
            errors++; checks++;
            $display("FAIL resp_timeout: is_output_valid got %b required 1 addr %h", is_output_valid, a);
            return;
        end
        rdata = dout;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        checks += 7;
        if (is_ready !== 1'b0)        begin errors++; $display("FAIL rst_ready: got %b required 0", is_ready); end
        if (is_output_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid: got %b required 0", is_output_valid); end
        if (dout !== 32'h0)           begin errors++; $display("FAIL rst_dout: got %h required 0", dout); end
        if (is_hit !== 1'b0)          begin errors++; $display("FAIL rst_hit: got %b required 0", is_hit); end
        if (mem_req_valid !== 1'b0)   begin errors++; $display("FAIL rst_mreq: got %b required 0", mem_req_valid); end
        if (hit_count !== 32'h0)      begin errors++; $display("FAIL rst_hitcnt: got %0d required 0", hit_count); end
        if (miss_count !== 32'h0)     begin errors++; $display("FAIL rst_misscnt: got %0d required 0", miss_count); end
        reset = 0;
        @(negedge clk);
        checks++;
        if (is_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", is_ready); end
    endtask

    task automatic test_cold_load();
        logic [31:0] got; int lat, rs;
        bk[32'h40 >> 2] = 32'hDEAD_BEEF;
        wb_addr_q.delete(); fetch_addr_q.delete(); resp_n = 3;
        do_request(32'h40, 1'b0, 32'h0, got, lat, rs);
        checks += 6;
        if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_data: got %h required deadbeef", got); end
        if (is_hit !== 1'b0)       begin errors++; $display("FAIL cold_hit: got %b required 0", is_hit); end
        if (miss_count !== 32'd1)  begin errors++; $display("FAIL cold_misscnt: got %0d required 1", miss_count); end
        if (lat !== 7)             begin errors++; $display("FAIL cold_latency: got %0d required 7", lat); end
        if (fetch_addr_q.size() != 1 || wb_addr_q.size() != 0) begin
            errors++; $display("FAIL cold_traffic: fetches %0d wbs %0d required 1 0", fetch_addr_q.size(), wb_addr_q.size());
        end else if (fetch_addr_q[0] !== 32'h40) begin
            errors++; $display("FAIL cold_fetch_addr: got %h required 40", fetch_addr_q[0]);
        end
        if (rs != 0) begin errors++; $display("FAIL cold_ready_busy: got %0d ready cycles required 0", rs); end
    endtask

    task automatic test_hit_load();
        logic [31:0] got; int lat, rs;
        fetch_addr_q.delete(); wb_addr_q.delete();
        do_request(32'h40, 1'b0, 32'h0, got, lat, rs);
        checks += 6;
        if (lat !== 1)             begin errors++; $display("FAIL hit_latency: got %0d required 1", lat); end
        if (got !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_data: got %h required deadbeef", got); end
        if (is_hit !== 1'b1)       begin errors++; $display("FAIL hit_flag: got %b required 1", is_hit); end
        if (hit_count !== 32'd1)   begin errors++; $display("FAIL hit_count: got %0d required 1", hit_count); end
        if (is_ready !== 1'b1)     begin errors++; $display("FAIL hit_ready_t2: got %b required 1", is_ready); end
        if (fetch_addr_q.size() + wb_addr_q.size() != 0) begin
            errors++; $display("FAIL hit_traffic: got %0d requests required 0", fetch_addr_q.size() + wb_addr_q.size());
        end
    endtask

    task automatic test_store_load();
        logic [31:0] got; int lat, rs;
        fetch_addr_q.delete(); wb_addr_q.delete();
        do_request(32'h44, 1'b1, 32'h1234_5678, got, lat, rs);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL store_latency: got %0d required 1", lat); end
        do_request(32'h44, 1'b0, 32'h0, got, lat, rs);
        checks += 3;
        if (got !== 32'h1234_5678) begin errors++; $display("FAIL store_readback: got %h required 12345678", got); end
        if (hit_count !== 32'd3)   begin errors++; $display("FAIL store_hitcnt: got %0d required 3", hit_count); end
        if (fetch_addr_q.size() + wb_addr_q.size() != 0) begin
            errors++; $display("FAIL store_traffic: got %0d requests required 0", fetch_addr_q.size() + wb_addr_q.size());
        end
    endtask

    task automatic test_writeback_stall();
        logic [31:0] got; int lat, rs;
        fetch_addr_q.delete(); wb_addr_q.delete(); wb_data_q.delete();
        stable_err = 0; wb_stall = 5;
        do_request(32'h140, 1'b0, 32'h0, got, lat, rs);
        wb_stall = 0;
        checks += 6;
        if (wb_addr_q.size() != 1 || fetch_addr_q.size() != 1) begin
            errors++; $display("FAIL evict_traffic: wbs %0d fetches %0d required 1 1", wb_addr_q.size(), fetch_addr_q.size());
        end else begin
            if (wb_addr_q[0] !== 32'h40) begin errors++; $display("FAIL evict_addr: got %h required 40", wb_addr_q[0]); end
            if (wb_data_q[0][63:32] !== 32'h1234_5678 || wb_data_q[0][31:0] !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL evict_data: got %h required words 1/0 12345678/deadbeef", wb_data_q[0]);
            end
            if (fetch_addr_q[0] !== 32'h140) begin errors++; $display("FAIL evict_fetch_addr: got %h required 140", fetch_addr_q[0]); end
        end
        if (stable_err != 0) begin errors++; $display("FAIL wb_hold_stable: got %0d changes required 0", stable_err); end
        if (rs != 0)         begin errors++; $display("FAIL wb_ready_busy: got %0d ready cycles required 0", rs); end
        if (lat !== 13)      begin errors++; $display("FAIL wb_latency: got %0d required 13", lat); end
        checks++;
        if (got !== init_word(32'h140 >> 2)) begin errors++; $display("FAIL evict_load: got %h required %h", got, init_word(32'h140 >> 2)); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] got; int lat, rs, n, pulses;
        fetch_addr_q.delete(); wb_addr_q.delete();
        hold_resp = 1; n = 0;
        @(negedge clk);
        while (!is_ready && n < 50) begin @(negedge clk); n++; end
        is_input_valid = 1; addr = 32'h280; mem_rw = 1'b0;
        @(negedge clk);
        is_input_valid = 0; n = 0;
        while (fetch_addr_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (fetch_addr_q.size() == 0) begin errors++; $display("FAIL midrst_fetch: got 0 fetches required 1"); end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        checks += 2;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_mreq: got %b required 0", mem_req_valid); end
        if (miss_count !== 32'h0)   begin errors++; $display("FAIL midrst_misscnt: got %0d required 0", miss_count); end
        reset = 0; hold_resp = 0; inject_resp = 1;
        pulses = 0;
        repeat (4) begin @(negedge clk); if (is_output_valid) pulses++; end
        checks += 2;
        if (pulses != 0)       begin errors++; $display("FAIL midrst_stale_resp: got %0d pulses required 0", pulses); end
        if (is_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b required 1", is_ready); end
        fetch_addr_q.delete();
        do_request(32'h280, 1'b0, 32'h0, got, lat, rs);
        checks += 3;
        if (is_hit !== 1'b0)      begin errors++; $display("FAIL midrst_remiss: got %b required 0", is_hit); end
        if (miss_count !== 32'd1) begin errors++; $display("FAIL midrst_misscnt2: got %0d required 1", miss_count); end
        if (got !== init_word(32'h280 >> 2)) begin errors++; $display("FAIL midrst_data: got %h required %h", got, init_word(32'h280 >> 2)); end
    endtask

    task automatic test_random();
        bit m_valid[16], m_dirty[16];
        logic [23:0] m_tag[16];
        logic [23:0] tags[4];
        int m_hits = 0, m_misses = 0;
        logic [23:0] tg; logic [3:0] ix; logic [1:0] wd;
        logic [31:0] a, d, got, exp_load, exp_wb_addr;
        logic [LBITS-1:0] exp_line;
        logic rw; bit exp_hit, exp_wb;
        int lat, rs;
        tags[0] = 24'h0; tags[1] = 24'h1; tags[2] = 24'h2; tags[3] = 24'hABCDE;
        for (int s = 0; s < 16; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = '0; end
        @(negedge clk); reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        ref_mem = bk;
        stable_err = 0; idle_err = 0;
        for (int i = 0; i < 150; i++) begin
            tg = tags[$urandom_range(0, 3)];
            ix = 4'($urandom_range(0, 7));
            wd = 2'($urandom_range(0, 3));
            a = {tg, ix, wd, 2'b00};
            rw = 1'($urandom_range(0, 1));
            d = $urandom;
            wb_stall = $urandom_range(0, 2); fetch_stall = $urandom_range(0, 2); resp_n = $urandom_range(1, 4);
            exp_hit = m_valid[ix] && (m_tag[ix] == tg);
            exp_wb = !exp_hit && m_valid[ix] && m_dirty[ix];
            exp_wb_addr = {m_tag[ix], ix, 4'h0};
            for (int w = 0; w < 4; w++) exp_line[w*32 +: 32] = ref_word((exp_wb_addr >> 2) + w);
            exp_load = ref_word(a >> 2);
            wb_addr_q.delete(); wb_data_q.delete(); fetch_addr_q.delete();
            do_request(a, rw, d, got, lat, rs);
            checks += 4;
            if (is_hit !== exp_hit) begin errors++; $display("FAIL rand_hit[%0d]: got %b required %b addr %h", i, is_hit, exp_hit, a); end
            if (wb_addr_q.size() != (exp_wb ? 1 : 0)) begin
                errors++; $display("FAIL rand_wb_count[%0d]: got %0d required %0d", i, wb_addr_q.size(), exp_wb ? 1 : 0);
            end else if (exp_wb) begin
                checks += 2;
                if (wb_addr_q[0] !== exp_wb_addr) begin errors++; $display("FAIL rand_wb_addr[%0d]: got %h required %h", i, wb_addr_q[0], exp_wb_addr); end
                if (wb_data_q[0] !== exp_line)    begin errors++; $display("FAIL rand_wb_data[%0d]: got %h required %h", i, wb_data_q[0], exp_line); end
            end
            if (fetch_addr_q.size() != (exp_hit ? 0 : 1)) begin
                errors++; $display("FAIL rand_fetch_count[%0d]: got %0d required %0d", i, fetch_addr_q.size(), exp_hit ? 0 : 1);
            end else if (!exp_hit) begin
                checks++;
                if (fetch_addr_q[0] !== {a[31:4], 4'h0}) begin errors++; $display("FAIL rand_fetch_addr[%0d]: got %h required %h", i, fetch_addr_q[0], {a[31:4], 4'h0}); end
            end
            if (rs != 0) begin errors++; $display("FAIL rand_ready_busy[%0d]: got %0d required 0", i, rs); end
            if (exp_hit) begin
                checks++;
                if (lat != 1) begin errors++; $display("FAIL rand_hit_latency[%0d]: got %0d required 1", i, lat); end
            end
            if (rw == 1'b0) begin
                checks++;
                if (got !== exp_load) begin errors++; $display("FAIL rand_load[%0d]: got %h required %h addr %h", i, got, exp_load, a); end
            end
            if (exp_hit) m_hits++; else m_misses++;
            if (!exp_hit) begin m_valid[ix] = 1; m_tag[ix] = tg; m_dirty[ix] = 0; end
            if (rw == 1'b1) begin m_dirty[ix] = 1; ref_mem[a >> 2] = d; end
        end
        checks += 4;
        if (hit_count !== 32'(m_hits))     begin errors++; $display("FAIL rand_hitcnt: got %0d required %0d", hit_count, m_hits); end
        if (miss_count !== 32'(m_misses))  begin errors++; $display("FAIL rand_misscnt: got %0d required %0d", miss_count, m_misses); end
        if (stable_err != 0) begin errors++; $display("FAIL rand_req_stable: got %0d changes required 0", stable_err); end
        if (idle_err != 0)   begin errors++; $display("FAIL rand_idle_zero: got %0d nonzero cycles required 0", idle_err); end
    endtask

    initial begin
        reset = 1; is_input_valid = 0; addr = '0; mem_rw = 0; din = '0;
        test_reset();
        test_cold_load();
        test_hit_load();
        test_store_load();
        test_writeback_stall();
        test_reset_mid_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
